// File: rtl/timer_apb_bridge.sv
// Core-to-timer bridge: owns TMCON/LOAD/STATUS/IRQEN, drives APB-style reload writes
// with PREADY wait and timeout, and turns the timer rollover pulse into a sticky interrupt.
module timer_apb_bridge #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [6:0]        TMCON,
  output logic              P_SEL,
  output logic              P_EN,
  output logic              PWRITE,
  output logic [15:0]       PWDATA,
  input  logic              PREADY,
  input  logic              tm_int_flag,
  output logic              irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCAL,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_LOAD   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_IRQEN  = ADDR_W'(3);
  localparam logic [7:0]        WAIT_MAX = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [6:0]  tmcon_q, tmcon_d;
  logic [15:0] load_q, load_d;
  logic [15:0] pwdata_q, pwdata_d;
  logic [1:0]  status_q, status_d;
  logic        irqen_q, irqen_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        sync1_q, sync2_q, prev_q;

  logic        mapped;
  logic        int_edge;
  logic [15:0] rd_mux;

  assign mapped   = (req_addr >> 2) == '0;
  assign int_edge = sync2_q & ~prev_q;

  always_comb begin
    rd_mux = '0;
    unique case (req_addr)
      A_CTRL:   rd_mux = {9'd0, tmcon_q};
      A_LOAD:   rd_mux = load_q;
      A_STATUS: rd_mux = {14'd0, status_q};
      A_IRQEN:  rd_mux = {15'd0, irqen_q};
      default:  rd_mux = '0;
    endcase
  end

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    tmcon_d    = tmcon_q;
    load_d     = load_q;
    pwdata_d   = pwdata_q;
    status_d   = status_q;
    irqen_d    = irqen_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rdata_d = rd_mux;
          err_d   = ~mapped;
          if (req_write && req_addr == A_LOAD) begin
            load_d   = req_wdata;
            pwdata_d = req_wdata;
            state_d  = S_SETUP;
          end else begin
            state_d = S_LOCAL;
            if (req_write) begin
              if (req_addr == A_CTRL)   tmcon_d  = req_wdata[6:0];
              if (req_addr == A_STATUS) status_d = status_q & ~req_wdata[1:0];
              if (req_addr == A_IRQEN)  irqen_d  = req_wdata[0];
            end
          end
        end
      end
      S_LOCAL: state_d = S_IDLE;
      S_SETUP: begin
        wait_cnt_d = '0;
        state_d    = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (wait_cnt_q == WAIT_MAX) begin
          err_d       = 1'b1;
          status_d[1] = 1'b1;
          state_d     = S_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A fresh rollover edge beats a simultaneous write-1-to-clear of the pending bit.
    if (int_edge) status_d[0] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      tmcon_q    <= '0;
      load_q     <= '0;
      pwdata_q   <= '0;
      status_q   <= '0;
      irqen_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmcon_q    <= tmcon_d;
      load_q     <= load_d;
      pwdata_q   <= pwdata_d;
      status_q   <= status_d;
      irqen_q    <= irqen_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
      sync1_q    <= tm_int_flag;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
    end
  end

  // Strobes decode straight from the state so a reset edge drops them immediately.
  assign req_ready = rst & (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_LOCAL) | (state_q == S_DONE);
  assign rsp_rdata = (state_q == S_LOCAL) ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;
  assign P_SEL     = (state_q == S_SETUP) | (state_q == S_ACCESS);
  assign P_EN      = (state_q == S_ACCESS);
  assign PWRITE    = P_SEL;
  assign PWDATA    = pwdata_q;
  assign TMCON     = tmcon_q;
  assign irq       = status_q[0] & irqen_q;

endmodule
